// File: rtl/joypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : joypad_pkg
// Description : Shared types and constants for the NES controller port.
//               - scan_state_t : pad scanner FSM states
//               - BTN_*        : bit positions of each button in a snapshot
//               - OPEN_BUS_HI  : upper 7 bits returned on $4016/$4017 reads
// Revision    : 1.0 - initial release
// ============================================================================
package joypad_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        CLK_HI = 3'd2,
        CLK_LO = 3'd3,
        COMMIT = 3'd4
    } scan_state_t;

    // Serial order out of the pad shift register, bit0 first.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Bit 6 set mimics the open-bus residue of the $40xx address high byte.
    localparam logic [6:0] OPEN_BUS_HI = 7'b0100000;

endpackage : joypad_pkg
`default_nettype wire

// File: rtl/joypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : joypad_scanner
// Description : Scans two NES pads once per scan_req rising edge. Drives the
//               shared latch/clock lines, samples both serial data lines
//               through 2-FF synchronisers and commits both snapshots on the
//               same edge when all 8 bits are in.
// Ports       : CLOCK_50, reset (async, active-high)
//               scan_req              - rising edge starts a scan
//               pad1/2_data_n         - serial pad data, active-low, async
//               pad_latch, pad_clk    - shared pad control lines
//               buttons1/2            - committed snapshots, 1 = pressed
//               scan_busy             - high while a scan is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module joypad_scanner
    import joypad_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int LATCH_US = 12,
    parameter int PULSE_US = 6
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       scan_req,
    input  logic       pad1_data_n,
    input  logic       pad2_data_n,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons1,
    output logic [7:0] buttons2,
    output logic       scan_busy
);

    localparam int LATCH_CYC = CLK_HZ / 1_000_000 * LATCH_US;
    localparam int PULSE_CYC = CLK_HZ / 1_000_000 * PULSE_US;
    localparam int CNT_MAX   = (LATCH_CYC > PULSE_CYC) ? LATCH_CYC : PULSE_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] c_LATCH_LAST = CNT_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0] c_PULSE_LAST = CNT_W'(PULSE_CYC - 1);

    logic [1:0]       r_p1_sync;
    logic [1:0]       r_p2_sync;
    logic             r_scan_req_d;
    scan_state_t      r_state;
    logic [CNT_W-1:0] r_cyc;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_tmp1;
    logic [7:0]       r_tmp2;

    logic             w_p1_pressed;
    logic             w_p2_pressed;
    logic             w_scan_rise;

    // Synchronisers idle at 1 (released / not pressed).
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_p1_sync    <= 2'b11;
            r_p2_sync    <= 2'b11;
            r_scan_req_d <= 1'b0;
        end else begin
            r_p1_sync    <= {r_p1_sync[0], pad1_data_n};
            r_p2_sync    <= {r_p2_sync[0], pad2_data_n};
            r_scan_req_d <= scan_req;
        end
    end

    assign w_p1_pressed = ~r_p1_sync[1];
    assign w_p2_pressed = ~r_p2_sync[1];
    assign w_scan_rise  = scan_req & ~r_scan_req_d;

    // Edges arriving outside IDLE are simply dropped, never queued.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cyc     <= '0;
            r_bitcnt  <= 3'd0;
            r_tmp1    <= 8'h00;
            r_tmp2    <= 8'h00;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            scan_busy <= 1'b0;
            buttons1  <= 8'h00;
            buttons2  <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cyc <= '0;
                    if (w_scan_rise) begin
                        r_state   <= LATCH;
                        pad_latch <= 1'b1;
                        scan_busy <= 1'b1;
                    end
                end
                LATCH: begin
                    if (r_cyc == c_LATCH_LAST) begin
                        // Latch high presents bit0 on both data lines.
                        r_tmp1[0] <= w_p1_pressed;
                        r_tmp2[0] <= w_p2_pressed;
                        r_bitcnt  <= 3'd1;
                        r_cyc     <= '0;
                        pad_latch <= 1'b0;
                        pad_clk   <= 1'b1;
                        r_state   <= CLK_HI;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                CLK_HI: begin
                    if (r_cyc == c_PULSE_LAST) begin
                        r_cyc   <= '0;
                        pad_clk <= 1'b0;
                        r_state <= CLK_LO;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                CLK_LO: begin
                    if (r_cyc == c_PULSE_LAST) begin
                        // Sample at the end of the low phase so the pad's
                        // post-clock data has long settled.
                        r_tmp1[r_bitcnt] <= w_p1_pressed;
                        r_tmp2[r_bitcnt] <= w_p2_pressed;
                        r_cyc            <= '0;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= COMMIT;
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            pad_clk  <= 1'b1;
                            r_state  <= CLK_HI;
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                COMMIT: begin
                    buttons1  <= r_tmp1;
                    buttons2  <= r_tmp2;
                    scan_busy <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b0;
                    scan_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule : joypad_scanner
`default_nettype wire

// File: rtl/joypad_port.sv
`default_nettype none
// ============================================================================
// Module      : joypad_port
// Description : NES $4016/$4017 controller registers. A scanner fills the
//               pad snapshots once per frame; the CPU strobes them into two
//               shift registers and reads them out serially.
// Ports       : CLOCK_50, reset (async, active-high)
//               cpu_ce/cs/addr0/we/data_in - CPU bus access
//               cpu_data_out               - read data (combinational)
//               scan_req                   - rising edge starts a pad scan
//               pad_latch, pad_clk         - shared pad control lines
//               pad1/2_data_n              - serial pad data, active-low
//               buttons1/2, scan_busy      - snapshots and scan status
// Revision    : 1.0 - initial release
// ============================================================================
module joypad_port
    import joypad_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int LATCH_US = 12,
    parameter int PULSE_US = 6
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       cpu_ce,
    input  logic       cpu_cs,
    input  logic       cpu_addr0,
    input  logic       cpu_we,
    input  logic [7:0] cpu_data_in,
    output logic [7:0] cpu_data_out,
    input  logic       scan_req,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic       pad1_data_n,
    input  logic       pad2_data_n,
    output logic [7:0] buttons1,
    output logic [7:0] buttons2,
    output logic       scan_busy
);

    logic       r_strobe;
    logic [7:0] r_shift1;
    logic [7:0] r_shift2;

    logic       w_acc;
    logic       w_strobe_wr;
    logic       w_read;
    logic       w_sel_bit;
    logic       w_unused_data;

    joypad_scanner #(
        .CLK_HZ   (CLK_HZ),
        .LATCH_US (LATCH_US),
        .PULSE_US (PULSE_US)
    ) u_scanner (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .scan_req    (scan_req),
        .pad1_data_n (pad1_data_n),
        .pad2_data_n (pad2_data_n),
        .pad_latch   (pad_latch),
        .pad_clk     (pad_clk),
        .buttons1    (buttons1),
        .buttons2    (buttons2),
        .scan_busy   (scan_busy)
    );

    assign w_acc         = cpu_ce & cpu_cs;
    assign w_strobe_wr   = w_acc & cpu_we & ~cpu_addr0;
    assign w_read        = w_acc & ~cpu_we;
    assign w_unused_data = ^cpu_data_in[7:1];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_strobe <= 1'b0;
        end else if (w_strobe_wr) begin
            r_strobe <= cpu_data_in[0];
        end
    end

    // Strobe high reloads every cycle, so reads see bit0 and never shift.
    // The reload samples the registered snapshot, so a same-cycle commit
    // lands one cycle later.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_shift1 <= 8'h00;
            r_shift2 <= 8'h00;
        end else if (r_strobe) begin
            r_shift1 <= buttons1;
            r_shift2 <= buttons2;
        end else if (w_read) begin
            // Fill with 1 so reads past the eighth return 1.
            if (cpu_addr0) begin
                r_shift2 <= {1'b1, r_shift2[7:1]};
            end else begin
                r_shift1 <= {1'b1, r_shift1[7:1]};
            end
        end
    end

    assign w_sel_bit    = cpu_addr0 ? r_shift2[0] : r_shift1[0];
    assign cpu_data_out = (cpu_cs && !cpu_we) ? {OPEN_BUS_HI, w_sel_bit} : 8'h00;

endmodule : joypad_port
`default_nettype wire

// File: doc/joypad_port.md
Name: joypad_port

Overview:
- CPU-side responder for the $4016/$4017 controller registers.
- Also the initiator toward two physical NES pads on GPIO: it drives shared latch and clock lines and samples two serial data lines.
- Once per frame, on `scan_req` (tied to the VGA vertical sync), it scans both pads into snapshot registers.
- The CPU strobes and serially reads those snapshots with standard NES semantics.

Parameters:
- CLK_HZ, 50_000_000, frequency of CLOCK_50.
- LATCH_US, 12, pad latch high time in µs; LATCH_CYC = CLK_HZ/1_000_000*LATCH_US = 600.
- PULSE_US, 6, pad clock high time and low time in µs; PULSE_CYC = 300.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- cpu_ce  in  1  one-cycle qualifier marking the CLOCK_50 cycle of a CPU bus access.
- cpu_cs  in  1  address decode hit for $4016–$4017.
- cpu_addr0  in  1  0 = $4016 (pad1), 1 = $4017 (pad2).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_data_in  in  8  CPU write data.
- cpu_data_out  out  8  CPU read data.
- scan_req  in  1  level input; rising edge requests a pad scan.
- pad_latch  out  1  shared pad latch, active-high.
- pad_clk  out  1  shared pad clock, active-high pulse.
- pad1_data_n  in  1  pad1 serial data, active-low, asynchronous.
- pad2_data_n  in  1  pad2 serial data, active-low, asynchronous.
- buttons1  out  8  committed pad1 snapshot, 1 = pressed.
- buttons2  out  8  committed pad2 snapshot, 1 = pressed.
- scan_busy  out  1  high while a scan is in progress.

Behaviour:
- Reset clock and polarity: reset asynchronous, active-high; clock CLOCK_50.
- Reset values: pad_latch, pad_clk, scan_busy = 0; buttons1/2 = 0; shift registers = 0; strobe = 0; FSM = IDLE.
- Reset mid-scan aborts the scan immediately; the partial snapshot is discarded.
- Bit order, bit0..bit7: A, B, Select, Start, Up, Down, Left, Right. pressed = ~synchronised data_n.
- pad*_data_n pass through a 2-FF synchroniser before any sampling.
- scan_req is edge-detected with a registered copy. A rising edge while busy is ignored, not queued.
- Scanner FSM:
  - IDLE: on scan_req rise go to LATCH; scan_busy = 1.
  - LATCH: pad_latch = 1 for LATCH_CYC cycles. On the last cycle, sample bit0 of both pads, bitcnt = 1, go to CLK_HI.
  - CLK_HI: pad_clk = 1 for PULSE_CYC cycles, then go to CLK_LO.
  - CLK_LO: pad_clk = 0 for PULSE_CYC cycles. On the last cycle, sample bit[bitcnt]. If bitcnt = 7 go to COMMIT, else bitcnt+1 and go to CLK_HI.
  - COMMIT: buttons1/2 ← temp registers (both updated on the same edge); scan_busy = 0; go to IDLE.
  - Total scan = 600 + 7×600 + 1 = 4801 cycles from the edge-detect cycle.
- CPU access:
  - Define acc = cpu_ce & cpu_cs.
  - Write: acc & cpu_we & ~cpu_addr0 gives strobe ← cpu_data_in[0]. Writes to $4017 are ignored.
  - While strobe = 1: each cycle, shift1 ← buttons1 and shift2 ← buttons2. Reads return bit0 and do not shift.
  - Strobe 1→0: the registers hold the last loaded value.
  - Read with strobe = 0: acc & ~cpu_we returns the selected shift[0]. On that edge the selected register shifts right with 1 filled into bit7. After 8 reads, every read returns 1.
  - cpu_data_out is combinational: {7'b0100000, bit} when cpu_cs & ~cpu_we, else 8'h00.
  - A COMMIT in the same cycle as a strobe-high reload loads the old snapshot. The new value loads on the next cycle.
  - A COMMIT has no effect on a shift in progress (strobe = 0).

Decomposition:
- Package joypad_pkg holds:
  - the scan_state_t enum {IDLE, LATCH, CLK_HI, CLK_LO, COMMIT};
  - button index constants BTN_A..BTN_RIGHT;
  - OPEN_BUS_HI = 7'b0100000.
- Sub-module joypad_scanner contains the synchroniser, edge detect, FSM, cycle counter, bit counter and temp registers. It outputs pad_latch, pad_clk, buttons1/2 and scan_busy.
- joypad_port is the top level: the scanner instance plus the strobe and the two CPU shift registers.

Test Plan:
1. Reset, then release: pad_latch = 0, pad_clk = 0, buttons1 = buttons2 = 8'h00, cpu_data_out = 8'h00, scan_busy = 0.
2. Pad1 model drives A and Start (data_n low on bits 0 and 3), then scan_req rises.
   - pad_latch is high for exactly 600 cycles.
   - Exactly 7 pad_clk pulses occur, each 300 high and 300 low.
   - buttons1 = 8'h09 after COMMIT; scan_busy is low 4801 cycles after the edge.
3. With buttons1 = 8'h09: write $4016 ← 1, then ← 0, then 10 reads of $4016.
   - data_out sequence: 41, 40, 40, 41, 40, 40, 40, 40, 41, 41.
4. Strobe held at 1: three reads of $4016 with buttons1 = 8'h09 all return 8'h41 and the shift register does not shift. Writing $4017 ← 1 leaves the strobe unchanged.
5. Pad2 presses Right only: after a scan, buttons2 = 8'h80. After strobe, $4017 reads 1–7 return 8'h40, read 8 returns 8'h41, read 9 returns 8'h41.
6. scan_req re-pulsed at cycle 1000 of a scan: ignored, and the scan ends at cycle 4801.
   - Reset asserted at cycle 2000 of a new scan: pad_latch = pad_clk = 0 and buttons = 0 immediately, FSM = IDLE.
   - After release, the next scan_req completes a normal scan.
